// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the control unit (master) and the memory
// responder (slave) on the MAR/MDR bus.
//   ena   : request strobe (master -> slave)
//   rw    : 1 = read, 0 = write (master -> slave)
//   wb    : 0 = word, 1 = byte access (master -> slave)
//   addr  : byte address, MAR (master -> slave)
//   wdata : write data, MDR out (master -> slave)
//   rdata : read data, MDR in (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
//   busy  : request in progress (slave -> master)
//   err   : access fault, qualified by done (slave -> master)
// -----------------------------------------------------------------------------
interface mem_responder_if;
   logic        ena;
   logic        rw;
   logic        wb;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        done;
   logic        busy;
   logic        err;

   modport master (
      output ena, rw, wb, addr, wdata,
      input  rdata, done, busy, err
   );

   modport slave (
      input  ena, rw, wb, addr, wdata,
      output rdata, done, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Target end of the control unit's rw/ena memory request bus. Accepts one
// request at a time, waits WAIT_STATES cycles, performs a little-endian word or
// byte access on internal 16-bit RAM and signals completion with a one-cycle
// done pulse.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_responder_if.slave (ena/rw/wb/addr/wdata in, rdata/done/busy/err out)
// Parameters:
//   DEPTH_WORDS : number of 16-bit RAM words (byte space = 2*DEPTH_WORDS)
//   WAIT_STATES : extra cycles before the access (0..15)
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, a word access to
// an odd byte address faults (no write, rdata held, err with done).
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic             clk,
   input  logic             rst,
   mem_responder_if.slave   bus
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [15:0] DEPTH_L = 16'(DEPTH_WORDS);
   localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [15:0] addr_q, wdata_q;
   logic        rw_q, wb_q;
   logic        latch_s;
   logic        mem_we_s;
   logic        oor_s;
   logic        misalign_s;
   logic [AW-1:0] widx_s;
   logic [15:0] rd_word_s;

   logic [15:0] mem_q [DEPTH_WORDS];

   // Word index beyond the RAM; the index is zero-extended so a depth of
   // 32768 words still compares correctly.
   function automatic logic out_of_range(input logic [14:0] idx);
      return ({1'b0, idx} >= DEPTH_L);
   endfunction

   // Byte writes replace only the addressed lane with wdata[7:0].
   function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic        byte_acc,
                                               input logic        lane);
      logic [15:0] res;
      if (!byte_acc) begin
         res = new_w;
      end else if (lane) begin
         res = {new_w[7:0], old_w[7:0]};
      end else begin
         res = {old_w[15:8], new_w[7:0]};
      end
      return res;
   endfunction

   assign oor_s     = out_of_range(addr_q[15:1]);
   assign widx_s    = addr_q[AW:1];
   assign rd_word_s = mem_q[widx_s];

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_s = ~wb_q & addr_q[0];
`else
   assign misalign_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; ena is only looked at while idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ena) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request latch, wait counter, access and next output values.
   always_comb begin
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = 1'b0;
      latch_s  = 1'b0;
      mem_we_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.ena) begin
               latch_s = 1'b1;
               cnt_d   = WS_L;
            end else begin
               cnt_d   = cnt_q;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Access edge. Out-of-range reads return zero; alignment
               // faults leave rdata alone; faulted writes are dropped.
               err_d = oor_s | misalign_s;
               if (oor_s) begin
                  if (rw_q) begin
                     rdata_d = 16'h0000;
                  end else begin
                     rdata_d = rdata_q;
                  end
               end else if (misalign_s) begin
                  rdata_d = rdata_q;
               end else if (rw_q) begin
                  if (!wb_q) begin
                     rdata_d = rd_word_s;
                  end else if (addr_q[0]) begin
                     rdata_d = {8'h00, rd_word_s[15:8]};
                  end else begin
                     rdata_d = {8'h00, rd_word_s[7:0]};
                  end
               end else begin
                  mem_we_s = 1'b1;
               end
            end
         end
         S_DONE: begin
            cnt_d = cnt_q;
         end
         default: begin
            cnt_d = 4'd0;
         end
      endcase
   end

   // Status outputs decoded from the next state so they come straight from flops.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Datapath registers: counter, latched request and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 4'd0;
         rdata_q <= 16'h0000;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rw_q    <= 1'b0;
         wb_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         if (latch_s) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rw_q    <= bus.rw;
            wb_q    <= bus.wb;
         end
      end
   end

   // RAM write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[widx_s] <= merge_bytes(mem_q[widx_s], wdata_q, wb_q, addr_q[0]);
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed self-checking bench for mem_responder with WAIT_STATES=2 and
// DEPTH_WORDS=1024. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_responder;
   localparam int DW = 1024;
   localparam int WS = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   mem_responder_if bus_if ();

   mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic drive(input logic r, input logic b, input logic [15:0] a, input logic [15:0] d);
      bus_if.rw    = r;
      bus_if.wb    = b;
      bus_if.addr  = a;
      bus_if.wdata = d;
   endtask

   // One complete request: checks latency (negedges after the accepting edge),
   // err, rdata, single-cycle done and return to idle.
   task automatic xact(input string tag, input logic r, input logic b,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic exp_err, input logic [15:0] exp_rd);
      int lat;
      lat = 0;
      @(negedge clk);
      drive(r, b, a, d);
      bus_if.ena = 1'b1;
      @(posedge clk);
      #1;
      bus_if.ena = 1'b0;
      drive(~r, ~b, ~a, ~d);   // latched fields must not follow the bus
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      check16({tag, " latency"}, 16'(lat), 16'(WS + 2));
      if (lat != 0) begin
         check1({tag, " err"}, bus_if.err, exp_err);
         check16({tag, " rdata"}, bus_if.rdata, exp_rd);
         @(negedge clk);
         check1({tag, " done width"}, bus_if.done, 1'b0);
         check1({tag, " idle"}, bus_if.busy, 1'b0);
      end
   endtask

   logic [15:0] exp5;
   int          n_done;

   initial begin
      rst = 1'b1;
      bus_if.ena = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check16("reset rdata", bus_if.rdata, 16'h0000);
      check1("reset done", bus_if.done, 1'b0);
      check1("reset busy", bus_if.busy, 1'b0);
      check1("reset err", bus_if.err, 1'b0);
      rst = 1'b0;

      // Word write/read
      xact("wr 0010",  1'b0, 1'b0, 16'h0010, 16'h1234, 1'b0, 16'h0000);
      xact("rd 0010",  1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234);

      // Byte lanes
      xact("bwr 0011", 1'b0, 1'b1, 16'h0011, 16'h00AB, 1'b0, 16'h1234);
      xact("rd ab34",  1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hAB34);
      xact("brd 0010", 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0034);
      xact("brd 0011", 1'b1, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'h00AB);
      xact("bwr 0010", 1'b0, 1'b1, 16'h0010, 16'hFFCD, 1'b0, 16'h00AB);
      xact("rd abcd",  1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hABCD);
      xact("wr 0020",  1'b0, 1'b0, 16'h0020, 16'h2020, 1'b0, 16'hABCD);

      // ena held high across a write: only one extra read gets in
      n_done = 0;
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0010, 16'h7777);
      bus_if.ena = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 16'h0020, 16'h0000);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) begin
            n_done++;
            break;
         end
      end
      @(negedge clk);
      check1("hold idle after done", bus_if.busy, 1'b0);
      @(posedge clk);
      #1;
      bus_if.ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) n_done++;
      end
      check16("hold done count", 16'(n_done), 16'd2);
      check16("hold rdata", bus_if.rdata, 16'h2020);
      xact("rd 7777",  1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h7777);

      // Odd-address word access
`ifdef MEM_ALIGN_CHECK_EN
      xact("wr odd",   1'b0, 1'b0, 16'h0011, 16'hBEEF, 1'b1, 16'h7777);
      exp5 = 16'h7777;
      xact("rd odd",   1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 16'h7777);
`else
      xact("wr odd",   1'b0, 1'b0, 16'h0011, 16'hBEEF, 1'b0, 16'h7777);
      exp5 = 16'hBEEF;
      xact("rd odd",   1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 16'h2020);
`endif
      xact("rd after odd", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, exp5);

      // Reset in WAIT aborts a write
      xact("wr 0030",  1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, exp5);
      xact("wr 0000",  1'b0, 1'b0, 16'h0000, 16'h1111, 1'b0, exp5);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0030, 16'h5555);
      bus_if.ena = 1'b1;
      @(posedge clk);
      #1;
      bus_if.ena = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check16("async rst rdata", bus_if.rdata, 16'h0000);
      check1("async rst busy", bus_if.busy, 1'b0);
      check1("async rst done", bus_if.done, 1'b0);
      check1("async rst err", bus_if.err, 1'b0);
      // rst and ena together: request must not be accepted
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      bus_if.ena = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_if.ena = 1'b0;
      check1("rst+ena busy", bus_if.busy, 1'b0);
      @(negedge clk);
      check1("rst+ena no done", bus_if.done, 1'b0);
      xact("rd pre",   1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, exp5);
      xact("rd 0030",  1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000);

      // Out of range
      xact("rd 0020b", 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h2020);
      xact("rd oor",   1'b1, 1'b0, 16'(2 * DW), 16'h0000, 1'b1, 16'h0000);
      xact("rd 0000",  1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1111);
      xact("wr oor",   1'b0, 1'b0, 16'(2 * DW), 16'hDEAD, 1'b1, 16'h1111);
      xact("rd alias", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1111);
      xact("brd oor",  1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
